// File: rtl/trisc_pkg.sv
// trisc_pkg: state encoding, opcodes and control-word layout shared by the sequencer
package trisc_pkg;

    typedef enum logic [3:0] {
        S_RST = 4'd0,
        S_F1  = 4'd1,
        S_F2  = 4'd2,
        S_F3  = 4'd3,
        S_DEC = 4'd4,
        S_INC = 4'd5,
        S_CLR = 4'd6,
        S_LDA = 4'd7,
        S_ADD = 4'd8,
        S_STA = 4'd9,
        S_JMP = 4'd10,
        S_BRZ = 4'd11,
        S_NOP = 4'd12,
        S_HLT = 4'd13
    } state_t;

    localparam logic [2:0] OP_INC = 3'd0;
    localparam logic [2:0] OP_CLR = 3'd1;
    localparam logic [2:0] OP_LDA = 3'd2;
    localparam logic [2:0] OP_ADD = 3'd3;
    localparam logic [2:0] OP_STA = 3'd4;
    localparam logic [2:0] OP_JMP = 3'd5;
    localparam logic [2:0] OP_BRZ = 3'd6;
    localparam logic [2:0] OP_HLT = 3'd7;

    localparam int CW_W   = 14;
    localparam int B_C0   = 0;
    localparam int B_C2   = 1;
    localparam int B_C3   = 2;
    localparam int B_C4   = 3;
    localparam int B_C42  = 4;
    localparam int B_C7   = 5;
    localparam int B_C8   = 6;
    localparam int B_C9   = 7;
    localparam int B_C5   = 8;
    localparam int B_C6   = 9;
    localparam int B_C10  = 10;
    localparam int B_C11  = 11;
    localparam int B_HALT = 12;
    localparam int B_ILL  = 13;

    // Opcodes beyond the eight defined ones all fall into the illegal-opcode state
    function automatic state_t dispatch(input logic [5:0] op);
        if (op[5:3] != 3'd0) return S_NOP;
        case (op[2:0])
            OP_INC:  return S_INC;
            OP_CLR:  return S_CLR;
            OP_LDA:  return S_LDA;
            OP_ADD:  return S_ADD;
            OP_STA:  return S_STA;
            OP_JMP:  return S_JMP;
            OP_BRZ:  return S_BRZ;
            default: return S_HLT;
        endcase
    endfunction

endpackage

// File: rtl/trisc_if.sv
// trisc_if: sequencer <-> datapath control and status bundle
interface trisc_if #(parameter int OPW = 3);

    logic [OPW-1:0] OP;
    logic Z, MRDY, RUN;
    logic C0, C2, C3, C4, C42, C7, C8, C9;
    logic C5, C6, C10, C11;
    logic HALT, ILL;

    modport master (
        input  OP, Z, MRDY, RUN,
        output C0, C2, C3, C4, C42, C7, C8, C9, C5, C6, C10, C11, HALT, ILL
    );

    modport slave (
        output OP, Z, MRDY, RUN,
        input  C0, C2, C3, C4, C42, C7, C8, C9, C5, C6, C10, C11, HALT, ILL
    );

endinterface

// File: rtl/trisc_ctrl_decode.sv
// trisc_ctrl_decode: Moore decode of the current state (plus Z for BRZ) into the control word
module trisc_ctrl_decode
    import trisc_pkg::*;
(
    input  state_t            state,
    input  logic              z,
    output logic [CW_W-1:0]   cw
);

    // One control pattern per state; unused encodings drive nothing
    always_comb begin
        cw = '0;
        case (state)
            S_RST: cw[B_C0] = 1'b1;
            S_F1:  cw[B_C3] = 1'b1;
            S_F2:  cw[B_C4] = 1'b1;
            S_F3:  cw[B_C42] = 1'b1;
            S_DEC: begin
                cw[B_C2] = 1'b1;
                cw[B_C7] = 1'b1;
            end
            S_INC: cw[B_C9] = 1'b1;
            S_CLR: cw[B_C8] = 1'b1;
            S_LDA: cw[B_C5] = 1'b1;
            S_ADD: cw[B_C10] = 1'b1;
            S_STA: cw[B_C6] = 1'b1;
            S_JMP: cw[B_C11] = 1'b1;
            S_BRZ: cw[B_C11] = z;
            S_NOP: cw[B_ILL] = 1'b1;
            S_HLT: cw[B_HALT] = 1'b1;
            default: cw = '0;
        endcase
    end

endmodule

// File: rtl/trisc_sequencer.sv
// trisc_sequencer: fetch/decode/execute control FSM for the TRISC datapath
module trisc_sequencer
    import trisc_pkg::*;
#(
    parameter int OPW      = 3,
    parameter int MEM_WAIT = 1
) (
    input  logic     clk,
    input  logic     CLR_n,
    trisc_if.master  bus
);

    state_t state, nxt;
    logic [OPW-1:0] op;
    logic [5:0] op6;
    logic rdy;
    logic [CW_W-1:0] cw;

    assign op  = bus.OP;
    assign op6 = 6'(op);
    assign rdy = (MEM_WAIT == 0) | bus.MRDY;

    // State register; reset forces RST at once, even mid memory-wait
    always_ff @(posedge clk or negedge CLR_n) begin
        if (!CLR_n) state <= S_RST;
        else        state <= nxt;
    end

    // Next state; stray encodings recover through RST
    always_comb begin
        nxt = S_RST;
        case (state)
            S_RST: nxt = S_F1;
            S_F1:  nxt = S_F2;
            S_F2:  nxt = rdy ? S_F3 : S_F2;
            S_F3:  nxt = S_DEC;
            S_DEC: nxt = dispatch(op6);
            S_INC, S_CLR, S_JMP, S_BRZ, S_NOP: nxt = S_F1;
            S_LDA, S_ADD, S_STA: nxt = rdy ? S_F1 : state;
            S_HLT: nxt = bus.RUN ? S_F1 : S_HLT;
            default: nxt = S_RST;
        endcase
    end

    trisc_ctrl_decode u_dec (
        .state (state),
        .z     (bus.Z),
        .cw    (cw)
    );

    assign bus.C0   = cw[B_C0];
    assign bus.C2   = cw[B_C2];
    assign bus.C3   = cw[B_C3];
    assign bus.C4   = cw[B_C4];
    assign bus.C42  = cw[B_C42];
    assign bus.C7   = cw[B_C7];
    assign bus.C8   = cw[B_C8];
    assign bus.C9   = cw[B_C9];
    assign bus.C5   = cw[B_C5];
    assign bus.C6   = cw[B_C6];
    assign bus.C10  = cw[B_C10];
    assign bus.C11  = cw[B_C11];
    assign bus.HALT = cw[B_HALT];
    assign bus.ILL  = cw[B_ILL];

endmodule

// File: tb/tb_trisc_sequencer.sv
// tb_trisc_sequencer: directed checks of the sequencer with wait-stalling and non-stalling memory
module tb_trisc_sequencer;

    localparam logic [13:0] K_C0   = 14'h0001;
    localparam logic [13:0] K_C2   = 14'h0002;
    localparam logic [13:0] K_C3   = 14'h0004;
    localparam logic [13:0] K_C4   = 14'h0008;
    localparam logic [13:0] K_C42  = 14'h0010;
    localparam logic [13:0] K_C7   = 14'h0020;
    localparam logic [13:0] K_C8   = 14'h0040;
    localparam logic [13:0] K_C9   = 14'h0080;
    localparam logic [13:0] K_C5   = 14'h0100;
    localparam logic [13:0] K_C6   = 14'h0200;
    localparam logic [13:0] K_C10  = 14'h0400;
    localparam logic [13:0] K_C11  = 14'h0800;
    localparam logic [13:0] K_HALT = 14'h1000;
    localparam logic [13:0] K_ILL  = 14'h2000;

    logic clk, ra_n, rb_n;
    logic [13:0] oa, ob;
    int n_chk, n_fail;

    trisc_if #(.OPW(4)) ba ();
    trisc_if #(.OPW(3)) bb ();

    trisc_sequencer #(.OPW(4), .MEM_WAIT(1)) dut_a (.clk(clk), .CLR_n(ra_n), .bus(ba));
    trisc_sequencer #(.OPW(3), .MEM_WAIT(0)) dut_b (.clk(clk), .CLR_n(rb_n), .bus(bb));

    assign oa = {ba.ILL, ba.HALT, ba.C11, ba.C10, ba.C6, ba.C5, ba.C9, ba.C8,
                 ba.C7, ba.C42, ba.C4, ba.C3, ba.C2, ba.C0};
    assign ob = {bb.ILL, bb.HALT, bb.C11, bb.C10, bb.C6, bb.C5, bb.C9, bb.C8,
                 bb.C7, bb.C42, bb.C4, bb.C3, bb.C2, bb.C0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [13:0] got, input logic [13:0] e);
        n_chk++;
        assert (got === e) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, e);
        end
    endtask

    task automatic tick(input string tag, input bit b, input logic [13:0] e);
        @(posedge clk);
        #1;
        chk(tag, b ? ob : oa, e);
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [13:0] exe);
        ba.OP = op;
        tick({tag, "_f2"}, 1'b0, K_C4);
        tick({tag, "_f3"}, 1'b0, K_C42);
        tick({tag, "_dec"}, 1'b0, K_C2 | K_C7);
        tick({tag, "_exe"}, 1'b0, exe);
        tick({tag, "_f1"}, 1'b0, K_C3);
    endtask

    logic [3:0]  ops [6];
    logic [13:0] exe [6];

    initial begin
        n_chk = 0;
        n_fail = 0;
        ops = '{4'd1, 4'd3, 4'd4, 4'd5, 4'd8, 4'd15};
        exe = '{K_C8, K_C10, K_C6, K_C11, K_ILL, K_ILL};
        ra_n = 1'b0; rb_n = 1'b0;
        ba.OP = 4'd0; ba.Z = 1'b0; ba.MRDY = 1'b1; ba.RUN = 1'b0;
        bb.OP = 3'd2; bb.Z = 1'b0; bb.MRDY = 1'b0; bb.RUN = 1'b0;
        #2;
        chk("rst_a", oa, K_C0);
        chk("rst_b", ob, K_C0);
        @(posedge clk);
        #1;
        chk("rst_hold", oa, K_C0);
        ra_n = 1'b1;
        #1;
        chk("rst_rel", oa, K_C0);
        tick("first_f1", 1'b0, K_C3);
        run_op("inc", 4'd0, K_C9);
        for (int i = 0; i < 6; i++) run_op("tbl", ops[i], exe[i]);
        ba.Z = 1'b1;
        run_op("brz_z1", 4'd6, K_C11);
        ba.Z = 1'b0;
        run_op("brz_z0", 4'd6, 14'h0000);
        ba.OP = 4'd2;
        tick("lda_f2", 1'b0, K_C4);
        tick("lda_f3", 1'b0, K_C42);
        tick("lda_dec", 1'b0, K_C2 | K_C7);
        ba.MRDY = 1'b0;
        for (int i = 0; i < 4; i++) tick("lda_wait", 1'b0, K_C5);
        ba.MRDY = 1'b1;
        tick("lda_f1", 1'b0, K_C3);
        ba.OP = 4'd7;
        ba.RUN = 1'b0;
        tick("hlt_f2", 1'b0, K_C4);
        tick("hlt_f3", 1'b0, K_C42);
        tick("hlt_dec", 1'b0, K_C2 | K_C7);
        for (int i = 0; i < 10; i++) tick("hlt_hold", 1'b0, K_HALT);
        ba.RUN = 1'b1;
        tick("hlt_f1", 1'b0, K_C3);
        ba.RUN = 1'b0;
        ba.OP = 4'd0;
        ba.MRDY = 1'b0;
        tick("f2_wait1", 1'b0, K_C4);
        tick("f2_wait2", 1'b0, K_C4);
        #2;
        ra_n = 1'b0;
        #1;
        chk("async_rst", oa, K_C0);
        tick("async_hold", 1'b0, K_C0);
        ra_n = 1'b1;
        ba.MRDY = 1'b1;
        tick("rerel_f1", 1'b0, K_C3);
        rb_n = 1'b1;
        tick("b_f1", 1'b1, K_C3);
        tick("b_f2", 1'b1, K_C4);
        tick("b_f3", 1'b1, K_C42);
        tick("b_dec", 1'b1, K_C2 | K_C7);
        tick("b_lda", 1'b1, K_C5);
        tick("b_f1b", 1'b1, K_C3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
